// File: rtl/x_flashsm_mc.sv
// rtl/x_flashsm_mc.sv - multi-channel LED flash pulse generator
// Each channel stretches a trigger into a visible flash with hold, retrigger and blink modes.
package x_flashsm_mc_pkg;
  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_FLASH = 3'd1,
    ST_HWAIT = 3'd2,
    ST_DARK  = 3'd3
  } state_t;
endpackage

module x_flashsm_mc
  import x_flashsm_mc_pkg::*;
#(
  parameter int NCH   = 8,
  parameter int MXCNT = 19
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [NCH-1:0]   trigger,
  input  logic [NCH-1:0]   hold,
  input  logic [2*NCH-1:0] mode,
  output logic [NCH-1:0]   out,
  output logic             out_any
);

  logic [NCH-1:0] w_out;
  logic           r_out_any;

  for (genvar gi = 0; gi < NCH; gi++) begin : g_ch
    state_t         r_state;
    state_t         w_state_nxt;
    logic           r_trig;
    logic           r_hold;
    logic           r_out;
    logic [MXCNT:0] r_cnt;
    logic [1:0]     w_mode;
    logic           w_done;
    logic           w_retrig;
    logic           w_clr;

    assign w_mode   = mode[2*gi +: 2];
    assign w_done   = r_cnt[MXCNT];
    assign w_retrig = (w_mode == 2'd1) && (r_state == ST_FLASH) && r_trig;
    // Clearing at cnt_done keeps the counter from ever reaching all-ones.
    assign w_clr    = (r_state == ST_IDLE) || (r_state == ST_HWAIT) || w_done || w_retrig;

    always_ff @(posedge clock) begin
      if (reset) begin
        r_state <= ST_IDLE;
      end else begin
        r_state <= w_state_nxt;
      end
    end

    always_comb begin
      w_state_nxt = r_state;
      if (w_mode == 2'd3) begin
        w_state_nxt = ST_IDLE;
      end else begin
        case (r_state)
          ST_IDLE: begin
            if (r_trig) w_state_nxt = ST_FLASH;
          end
          ST_FLASH: begin
            if (w_done) w_state_nxt = ((w_mode == 2'd2) && r_hold) ? ST_DARK : ST_HWAIT;
          end
          ST_HWAIT: begin
            if (!r_hold) w_state_nxt = ST_IDLE;
          end
          ST_DARK: begin
            if (w_mode != 2'd2)  w_state_nxt = ST_IDLE;
            else if (w_done)     w_state_nxt = r_hold ? ST_FLASH : ST_IDLE;
          end
          default: w_state_nxt = ST_IDLE;
        endcase
      end
    end

    always_ff @(posedge clock) begin
      if (reset) begin
        r_trig <= 1'b0;
        r_hold <= 1'b0;
        r_cnt  <= '0;
        r_out  <= 1'b0;
      end else begin
        r_trig <= trigger[gi];
        r_hold <= hold[gi] | trigger[gi];
        r_out  <= (r_state == ST_FLASH) || (r_state == ST_HWAIT);
        if (w_clr) begin
          r_cnt <= '0;
        end else if ((r_state == ST_FLASH) || (r_state == ST_DARK)) begin
          r_cnt <= r_cnt + 1'b1;
        end
      end
    end

    assign w_out[gi] = r_out;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_out_any <= 1'b0;
    end else begin
      r_out_any <= |w_out;
    end
  end

  assign out     = w_out;
  assign out_any = r_out_any;

endmodule

// File: tb/tb_x_flashsm_mc.sv
// tb/tb_x_flashsm_mc.sv - self-checking bench for x_flashsm_mc
// Phase/elapsed-time reference model, directed scenarios plus randomized traffic.
module tb_x_flashsm_mc;
  localparam int NCH   = 4;
  localparam int MXCNT = 2;
  localparam int PH    = (1 << MXCNT) + 1;
  localparam int P_IDLE = 0, P_ON = 1, P_EXT = 2, P_OFF = 3;

  logic             clock;
  logic             reset;
  logic [NCH-1:0]   trigger;
  logic [NCH-1:0]   hold;
  logic [2*NCH-1:0] mode;
  logic [NCH-1:0]   out;
  logic             out_any;

  int tests = 0;
  int fails = 0;

  int             ph [NCH];
  int             el [NCH];
  logic [NCH-1:0] m_out = '0;
  logic [NCH-1:0] m_tf  = '0;
  logic [NCH-1:0] m_hf  = '0;
  logic           m_any = 1'b0;

  x_flashsm_mc #(.NCH(NCH), .MXCNT(MXCNT)) dut (
    .clock   (clock),
    .reset   (reset),
    .trigger (trigger),
    .hold    (hold),
    .mode    (mode),
    .out     (out),
    .out_any (out_any)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  task automatic model_edge(input logic r, input logic [NCH-1:0] t, input logic [NCH-1:0] h,
                            input logic [2*NCH-1:0] md);
    logic [NCH-1:0] nout;
    int m;
    bit last;
    nout = '0;
    if (r) begin
      for (int c = 0; c < NCH; c++) begin
        ph[c] = P_IDLE;
        el[c] = 0;
      end
      m_out = '0; m_any = 1'b0; m_tf = '0; m_hf = '0;
      return;
    end
    m_any = |m_out;
    for (int c = 0; c < NCH; c++) begin
      m = int'(md[2*c +: 2]);
      nout[c] = (ph[c] == P_ON) || (ph[c] == P_EXT);
      last = (el[c] == PH - 1);
      if (m == 3) begin
        ph[c] = P_IDLE; el[c] = 0;
      end else begin
        case (ph[c])
          P_IDLE: if (m_tf[c]) begin ph[c] = P_ON; el[c] = 0; end
          P_ON: begin
            if (last) begin
              ph[c] = (m == 2 && m_hf[c]) ? P_OFF : P_EXT;
              el[c] = 0;
            end else if (m == 1 && m_tf[c]) el[c] = 0;
            else el[c]++;
          end
          P_EXT: if (!m_hf[c]) ph[c] = P_IDLE;
          default: begin
            if (m != 2) begin ph[c] = P_IDLE; el[c] = 0; end
            else if (last) begin ph[c] = m_hf[c] ? P_ON : P_IDLE; el[c] = 0; end
            else el[c]++;
          end
        endcase
      end
    end
    m_out = nout;
    m_tf  = t;
    m_hf  = h | t;
  endtask

  task automatic step();
    logic r;
    logic [NCH-1:0] t, h;
    logic [2*NCH-1:0] md;
    r = reset; t = trigger; h = hold; md = mode;
    @(posedge clock);
    model_edge(r, t, h, md);
    #1;
  endtask

  task automatic settle(input int n);
    trigger = '0; hold = '0;
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic test_reset();
    reset = 1'b1; trigger = '0; hold = '0; mode = '0;
    step(); step();
    tests++;
    if (out !== '0 || out_any !== 1'b0) begin
      fails++; $display("FAIL reset_out out=%b any=%b expected 0/0", out, out_any);
    end
    tests++;
    if (dut.g_ch[0].r_cnt !== '0 || dut.g_ch[0].r_state !== 3'd0) begin
      fails++; $display("FAIL reset_state cnt=%0d state=%0d expected 0/0", dut.g_ch[0].r_cnt, dut.g_ch[0].r_state);
    end
    reset = 1'b0;
    step();
  endtask

  task automatic test_single_flash();
    int highs, rise;
    mode = '0; hold = '0; trigger = '0; trigger[0] = 1'b1;
    step();
    trigger = '0;
    highs = 0; rise = -1;
    for (int i = 1; i <= 14; i++) begin
      step();
      tests++;
      if (out !== m_out || out_any !== m_any) begin
        fails++; $display("FAIL single_flash cyc=%0d out=%b exp=%b any=%b exp=%b", i, out, m_out, out_any, m_any);
      end
      if (out[0] === 1'b1) begin highs++; if (rise < 0) rise = i; end
    end
    tests++;
    if (rise != 2) begin fails++; $display("FAIL single_rise got=%0d expected=2", rise); end
    tests++;
    if (highs != PH + 1) begin fails++; $display("FAIL single_width got=%0d expected=%0d", highs, PH + 1); end
  endtask

  task automatic test_hold_extend();
    int highs;
    mode = '0; highs = 0;
    for (int i = 0; i < 30; i++) begin
      trigger = '0; hold = '0;
      trigger[1] = (i == 0 || i == 10);
      hold[1] = (i < 20);
      step();
      tests++;
      if (out !== m_out || out_any !== m_any) begin
        fails++; $display("FAIL hold_extend cyc=%0d out=%b exp=%b any=%b exp=%b", i, out, m_out, out_any, m_any);
      end
      if (out[1] === 1'b1) highs++;
      if (i == 12) begin
        tests++;
        if (dut.g_ch[1].r_cnt !== '0) begin
          fails++; $display("FAIL hold_cnt got=%0d expected=0", dut.g_ch[1].r_cnt);
        end
      end
    end
    tests++;
    if (highs != 20) begin fails++; $display("FAIL hold_width got=%0d expected=20", highs); end
    settle(4);
  endtask

  task automatic test_retrigger();
    int rises;
    logic prev;
    for (int pass = 0; pass < 2; pass++) begin
      mode = '0;
      mode[5:4] = (pass == 0) ? 2'd1 : 2'd0;
      rises = 0; prev = 1'b0;
      for (int i = 0; i < 25; i++) begin
        trigger = '0; hold = '0;
        trigger[2] = (i < 12) && (i % 3 == 0);
        step();
        tests++;
        if (out !== m_out || out_any !== m_any) begin
          fails++; $display("FAIL retrigger m%0d cyc=%0d out=%b exp=%b any=%b exp=%b", 1 - pass, i, out, m_out, out_any, m_any);
        end
        if (out[2] === 1'b1 && !prev) rises++;
        prev = out[2];
      end
      tests++;
      if (rises != 2 - (pass == 0 ? 1 : 0)) begin
        fails++; $display("FAIL retrigger_pulses m%0d got=%0d expected=%0d", 1 - pass, rises, (pass == 0) ? 1 : 2);
      end
    end
    mode = '0;
  endtask

  task automatic test_blink();
    int runs[$];
    int len;
    logic prev;
    bit started;
    mode = '0; mode[7:6] = 2'd2;
    len = 0; prev = 1'b0; started = 0;
    for (int i = 0; i < 50; i++) begin
      trigger = '0; hold = '0;
      trigger[3] = (i == 0);
      hold[3] = (i < 30);
      step();
      tests++;
      if (out !== m_out || out_any !== m_any) begin
        fails++; $display("FAIL blink cyc=%0d out=%b exp=%b any=%b exp=%b", i, out, m_out, out_any, m_any);
      end
      if (started && out[3] !== prev) begin runs.push_back(len); len = 0; end
      if (out[3] === 1'b1) started = 1;
      if (started) len++;
      prev = out[3];
    end
    tests++;
    if (runs.size() != 5) begin fails++; $display("FAIL blink_phases got=%0d expected=5", runs.size()); end
    foreach (runs[k]) begin
      tests++;
      if (runs[k] != PH) begin fails++; $display("FAIL blink_len phase=%0d got=%0d expected=%0d", k, runs[k], PH); end
    end
    tests++;
    if (out[3] !== 1'b0) begin fails++; $display("FAIL blink_end got=%b expected=0", out[3]); end
    mode = '0;
  endtask

  task automatic test_abort();
    mode = '0; hold = '0; trigger = '0; trigger[0] = 1'b1;
    step(); trigger = '0; step(); step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    tests++;
    if (out !== '0 || out !== m_out) begin fails++; $display("FAIL abort_reset out=%b expected=0", out); end
    step();
    tests++;
    if (dut.g_ch[0].r_cnt !== '0) begin fails++; $display("FAIL abort_reset_cnt got=%0d expected=0", dut.g_ch[0].r_cnt); end
    settle(3);
    trigger[0] = 1'b1;
    step(); trigger = '0; step(); step();
    mode[1:0] = 2'd3;
    step();
    tests++;
    if (out[0] !== 1'b1 || out !== m_out) begin fails++; $display("FAIL abort_mode3_e1 out=%b expected=%b", out, m_out); end
    step();
    tests++;
    if (out[0] !== 1'b0 || out !== m_out) begin fails++; $display("FAIL abort_mode3_e2 out=%b expected=%b", out, m_out); end
    step();
    tests++;
    if (dut.g_ch[0].r_cnt !== '0) begin fails++; $display("FAIL abort_mode3_cnt got=%0d expected=0", dut.g_ch[0].r_cnt); end
    for (int i = 0; i < 10; i++) begin
      trigger[0] = (i % 2 == 0);
      hold[0] = 1'b1;
      step();
      tests++;
      if (out[0] !== 1'b0 || out !== m_out) begin fails++; $display("FAIL disabled cyc=%0d out=%b expected=%b", i, out, m_out); end
    end
    mode = '0;
    settle(4);
  endtask

  task automatic test_illegal();
    int highs;
    settle(2);
    force dut.g_ch[0].r_state = x_flashsm_mc_pkg::state_t'(3'd5);
    step();
    release dut.g_ch[0].r_state;
    step();
    tests++;
    if (dut.g_ch[0].r_state !== 3'd0) begin fails++; $display("FAIL illegal_recover state=%0d expected=0", dut.g_ch[0].r_state); end
    step();
    tests++;
    if (out !== '0) begin fails++; $display("FAIL illegal_out out=%b expected=0", out); end
    trigger[0] = 1'b1;
    step();
    trigger = '0;
    highs = 0;
    for (int i = 0; i < 12; i++) begin
      step();
      tests++;
      if (out !== m_out || out_any !== m_any) begin
        fails++; $display("FAIL illegal_retrig cyc=%0d out=%b exp=%b", i, out, m_out);
      end
      if (out[0] === 1'b1) highs++;
    end
    tests++;
    if (highs != PH + 1) begin fails++; $display("FAIL illegal_width got=%0d expected=%0d", highs, PH + 1); end
  endtask

  task automatic test_back_to_back();
    mode = '0; hold = '0; trigger = '1;
    step();
    trigger = '0;
    for (int i = 0; i < 12; i++) begin
      step();
      tests++;
      if (out !== m_out || (out !== '0 && out !== '1)) begin
        fails++; $display("FAIL aligned cyc=%0d out=%b exp=%b", i, out, m_out);
      end
    end
    settle(3);
  endtask

  task automatic test_random();
    for (int i = 0; i < 600; i++) begin
      for (int c = 0; c < NCH; c++) begin
        trigger[c] = ($urandom_range(0, 9) == 0);
        if ($urandom_range(0, 7) == 0) hold[c] = ~hold[c];
        if ($urandom_range(0, 39) == 0) mode[2*c +: 2] = 2'($urandom_range(0, 3));
      end
      reset = ($urandom_range(0, 199) == 0);
      step();
      tests++;
      if (out !== m_out || out_any !== m_any) begin
        fails++; $display("FAIL random cyc=%0d out=%b exp=%b any=%b exp=%b", i, out, m_out, out_any, m_any);
      end
    end
    reset = 1'b0;
  endtask

  initial begin
    reset = 1'b1; trigger = '0; hold = '0; mode = '0;
    for (int c = 0; c < NCH; c++) begin ph[c] = P_IDLE; el[c] = 0; end
    test_reset();
    test_single_flash();
    test_hold_extend();
    test_retrigger();
    test_blink();
    test_abort();
    test_illegal();
    test_back_to_back();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
